// File: rtl/mux_16_pkg.sv
// Shared constants and the lane-slicing helper for the 16:1 registered selector.
// Used by the mux tree and by any model that needs the same slicing rule.
package mux_16_pkg;

    localparam int N_IN  = 16;
    localparam int SEL_W = 4;
    localparam int W_MAX = 64;

    // Returns lane s of a packed bus whose lanes are w bits wide (lane 0 in the LSBs).
    // The shift by s keeps an unknown select visible as X instead of folding it to a lane.
    function automatic logic [W_MAX-1:0] lane(
        input logic [N_IN*W_MAX-1:0] a,
        input logic [SEL_W-1:0]      s,
        input int                    w
    );
        logic [N_IN*W_MAX-1:0] shifted;
        logic [W_MAX-1:0]      mask;
        shifted = a >> (s * w);
        mask    = {W_MAX{1'b1}} >> (W_MAX - w);
        return W_MAX'(shifted) & mask;
    endfunction

endpackage

// File: rtl/mux_16_tree.sv
// Purely combinational 16:1 selector built as a balanced tree of 2:1 muxes.
// Level 0 is steered by s[0], level 3 by s[3].
module mux_16_tree
    import mux_16_pkg::*;
#(
    parameter int W = 1
) (
    input  logic [N_IN*W-1:0] a,
    input  logic [SEL_W-1:0]  s,
    output logic [W-1:0]      y
);

    logic [N_IN*W_MAX-1:0] a_ext_s;
    logic [W-1:0]          leaf_s [N_IN];
    logic [W-1:0]          l1_s   [8];
    logic [W-1:0]          l2_s   [4];
    logic [W-1:0]          l3_s   [2];

    // Zero-extend the lanes to the helper's widest bus and split them into leaves.
    always_comb begin
        a_ext_s = '0;
        a_ext_s[N_IN*W-1:0] = a;
        for (int k = 0; k < N_IN; k++) begin
            leaf_s[k] = W'(lane(a_ext_s, SEL_W'(k), W));
        end
    end

    // Four mux levels, LSB of the select nearest the leaves.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            l1_s[k] = s[0] ? leaf_s[2*k+1] : leaf_s[2*k];
        end
        for (int k = 0; k < 4; k++) begin
            l2_s[k] = s[1] ? l1_s[2*k+1] : l1_s[2*k];
        end
        for (int k = 0; k < 2; k++) begin
            l3_s[k] = s[2] ? l2_s[2*k+1] : l2_s[2*k];
        end
        y = s[3] ? l3_s[1] : l3_s[0];
    end

endmodule

// File: rtl/mux_16.sv
// 16:1 lane selector with a registered, enable-gated output.
// y reflects lane[s] sampled at the previous rising edge; no combinational path from a/s to y.
module mux_16
    import mux_16_pkg::*;
#(
    parameter int W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_IN*W-1:0] a,
    input  logic [SEL_W-1:0]  s,
    input  logic              en,
    output logic [W-1:0]      y
);

    logic [W-1:0] sel_s;
    logic [W-1:0] y_r;

    mux_16_tree #(
        .W (W)
    ) u_tree (
        .a (a),
        .s (s),
        .y (sel_s)
    );

    // Output register: async clear, capture the selected lane only when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_r <= '0;
        end else if (en) begin
            y_r <= sel_s;
        end else begin
            y_r <= y_r;
        end
    end

    assign y = y_r;

endmodule

// File: tb/tb_mux_16.sv
// Directed self-checking bench for mux_16 at W=1 and W=8.
module tb_mux_16;

    logic        clk;
    logic        rst_n;
    logic [15:0] a1;
    logic [3:0]  s1;
    logic        en1;
    logic [0:0]  y1;
    logic [127:0] a8;
    logic [3:0]  s8;
    logic        en8;
    logic [7:0]  y8;

    int checks;
    int failures;

    mux_16 #(.W(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a1),
        .s     (s1),
        .en    (en1),
        .y     (y1)
    );

    mux_16 #(.W(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a8),
        .s     (s8),
        .en    (en8),
        .y     (y8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input logic exp, input string tag);
        checks++;
        assert (y1 === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, y1, exp);
        end
    endtask

    task automatic chk8(input logic [7:0] exp, input string tag);
        checks++;
        assert (y8 === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, y8, exp);
        end
    endtask

    // Drive W=1 inputs on the falling edge, check just after the next rising edge.
    task automatic step1(input logic [15:0] av, input logic [3:0] sv, input logic ev,
                         input logic exp, input string tag);
        @(negedge clk);
        a1 = av; s1 = sv; en1 = ev;
        @(posedge clk);
        #1;
        chk1(exp, tag);
    endtask

    task automatic step8(input logic [3:0] sv, input logic ev,
                         input logic [7:0] exp, input string tag);
        @(negedge clk);
        s8 = sv; en8 = ev;
        @(posedge clk);
        #1;
        chk8(exp, tag);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n = 1'b0;
        a1 = 16'h0000; s1 = 4'h0; en1 = 1'b1;
        a8 = 128'h0;   s8 = 4'h0; en8 = 1'b1;
        for (int i = 0; i < 16; i++) a8[i*8 +: 8] = 8'hA0 + 8'(i);

        repeat (2) @(posedge clk);
        #1;
        chk1(1'b0, "reset_y1");
        chk8(8'h00, "reset_y8");
        @(negedge clk);
        rst_n = 1'b1;

        // Boundary lanes and mixed codes.
        step1(16'h8FF8, 4'h0, 1'b1, 1'b0, "s0_a8FF8");
        step1(16'h8FF9, 4'h0, 1'b1, 1'b1, "s0_a8FF9");
        step1(16'h7FFF, 4'hF, 1'b1, 1'b0, "s15_a7FFF");
        step1(16'h8FF9, 4'hF, 1'b1, 1'b1, "s15_a8FF9");
        step1(16'h7F0F, 4'h7, 1'b1, 1'b0, "s7_a7F0F");
        step1(16'h7F00, 4'h5, 1'b1, 1'b0, "s5_a7F00");
        step1(16'h1F11, 4'hC, 1'b1, 1'b1, "s12_a1F11");

        // Walking one across every lane/select pair.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                step1(16'h0001 << i, 4'(j), 1'b1, (i == j) ? 1'b1 : 1'b0, "walk1");
            end
        end

        // W=8 sweep, lane i = A0+i.
        for (int j = 0; j < 16; j++) begin
            step8(4'(j), 1'b1, 8'hA0 + 8'(j), "sweep8");
        end

        // Changes between edges do not reach y.
        step1(16'h0001, 4'h0, 1'b1, 1'b1, "pre_glitch");
        #2;
        a1 = 16'h0000; s1 = 4'h3;
        #1;
        chk1(1'b1, "no_comb_path");

        // Mid-cycle reset clears y at once and discards the capture on the next edge.
        step1(16'h0001, 4'h0, 1'b1, 1'b1, "pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        chk1(1'b0, "async_reset_y1");
        chk8(8'h00, "async_reset_y8");
        @(posedge clk);
        #1;
        chk1(1'b0, "reset_held_edge");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk1(1'b1, "first_capture_after_reset");

        // Enable low: y holds while a and s toggle.
        step1(16'h0001, 4'h0, 1'b0, 1'b1, "hold_a");
        step1(16'h0000, 4'h3, 1'b0, 1'b1, "hold_b");
        step1(16'hFFFE, 4'h0, 1'b0, 1'b1, "hold_c");
        step1(16'h0008, 4'h3, 1'b1, 1'b1, "reenable_a");
        step1(16'h0000, 4'h3, 1'b1, 1'b0, "reenable_b");

        step8(4'h9, 1'b1, 8'hA9, "w8_load");
        step8(4'h2, 1'b0, 8'hA9, "w8_hold");
        step8(4'hE, 1'b0, 8'hA9, "w8_hold2");
        step8(4'h2, 1'b1, 8'hA2, "w8_reenable");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
